// File: rtl/hm_multipass_ctrl.sv
// Hashing-module controller: sequences NUM_PASSES chained hash passes per nonce
// and sweeps the nonce from a captured start to a captured end value.
module hm_multipass_ctrl #(
  parameter int NUM_PASSES = 3,
  parameter int PASS_W     = 2,
  parameter int ROUNDS     = 64,
  parameter int ROUND_W    = 6,
  parameter int NONCE_W    = 32
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               begin_hash,
  input  logic               quit_hash,
  input  logic [NONCE_W-1:0] nonce_start,
  input  logic [NONCE_W-1:0] nonce_end,
  input  logic               valid_hash_flag,
  output logic               init,
  output logic               cnt_up,
  output logic [ROUND_W-1:0] round_idx,
  output logic               out_load,
  output logic               chain,
  output logic [PASS_W-1:0]  pass_sel,
  output logic [NONCE_W-1:0] nonce,
  output logic               increment,
  output logic               busy,
  output logic               hash_done,
  output logic               found,
  output logic               exhausted
);

  typedef enum logic [2:0] {
    IDLE, INIT, CALC, OUT_LOAD, CHECK, INCR, HOLD, EXHAUST
  } state_t;

  localparam logic [PASS_W-1:0]  LAST_PASS  = PASS_W'(NUM_PASSES - 1);
  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(ROUNDS - 1);

  state_t               state, state_n;
  logic [PASS_W-1:0]    pass_n;
  logic [ROUND_W-1:0]   round_n;
  logic [NONCE_W-1:0]   nonce_n, end_q, end_n;

  always_comb begin
    state_n = state;
    pass_n  = pass_sel;
    round_n = round_idx;
    nonce_n = nonce;
    end_n   = end_q;
    if (quit_hash) begin
      state_n = IDLE;
      pass_n  = '0;
      round_n = '0;
    end else begin
      case (state)
        IDLE, EXHAUST: begin
          if (begin_hash) begin
            nonce_n = nonce_start;
            end_n   = nonce_end;
            pass_n  = '0;
            state_n = INIT;
          end
        end
        INIT: begin
          round_n = '0;
          state_n = CALC;
        end
        CALC: begin
          // round_idx returns to 0 after the last round so it only ever
          // shows 0..ROUNDS-1, whatever ROUNDS is
          if (round_idx == LAST_ROUND) begin
            round_n = '0;
            state_n = OUT_LOAD;
          end else begin
            round_n = round_idx + ROUND_W'(1);
          end
        end
        OUT_LOAD: begin
          if (pass_sel == LAST_PASS) begin
            state_n = CHECK;
          end else begin
            pass_n  = pass_sel + PASS_W'(1);
            state_n = INIT;
          end
        end
        CHECK: begin
          if (valid_hash_flag)    state_n = HOLD;
          else if (nonce == end_q) state_n = EXHAUST;
          else                     state_n = INCR;
        end
        INCR: begin
          nonce_n = nonce + NONCE_W'(1);
          pass_n  = '0;
          state_n = INIT;
        end
        HOLD: begin
          if (begin_hash) state_n = (nonce == end_q) ? EXHAUST : INCR;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next-state decode, so they line up
  // with the state register and have no path from the inputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      pass_sel  <= '0;
      round_idx <= '0;
      nonce     <= '0;
      end_q     <= '0;
      init      <= 1'b0;
      cnt_up    <= 1'b0;
      out_load  <= 1'b0;
      chain     <= 1'b0;
      increment <= 1'b0;
      busy      <= 1'b0;
      hash_done <= 1'b0;
      found     <= 1'b0;
      exhausted <= 1'b0;
    end else begin
      state     <= state_n;
      pass_sel  <= pass_n;
      round_idx <= round_n;
      nonce     <= nonce_n;
      end_q     <= end_n;
      init      <= (state_n == INIT);
      cnt_up    <= (state_n == CALC);
      out_load  <= (state_n == OUT_LOAD);
      chain     <= (pass_n != '0);
      increment <= (state_n == INCR);
      busy      <= (state_n != IDLE) && (state_n != HOLD) && (state_n != EXHAUST);
      hash_done <= (state_n == CHECK) || (state_n == HOLD) || (state_n == EXHAUST);
      found     <= (state_n == HOLD);
      exhausted <= (state_n == EXHAUST);
    end
  end

endmodule

// File: tb/tb_hm_multipass_ctrl.sv
// Bench for hm_multipass_ctrl: directed scenarios plus randomized traffic
// checked every cycle against an attempt-offset reference model.
module tb_hm_multipass_ctrl;
  localparam int NP = 3;
  localparam int R  = 4;
  localparam int A  = NP * (R + 2) + 2;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic beg = 1'b0, quit = 1'b0, flag = 1'b0;
  logic [31:0] ns = '0, ne = '0;

  logic init, cnt_up, out_load, chain, increment, busy, hash_done, found, exhausted;
  logic [1:0]  round_idx, pass_sel;
  logic [31:0] nonce;

  logic s_beg = 1'b0, s_quit = 1'b0, s_flag = 1'b0;
  logic [31:0] s_ns = '0, s_ne = '0;
  logic s_init, s_cnt_up, s_out_load, s_chain, s_increment, s_busy, s_hash_done, s_found, s_exhausted;
  logic [0:0]  s_round_idx, s_pass_sel;
  logic [31:0] s_nonce;

  int n_tests = 0;
  int n_fail  = 0;

  int          m_mode;  // 0 idle, 1 running attempt, 2 hold, 3 exhausted
  int          m_off;   // cycle offset within the running attempt
  logic [31:0] m_nonce, m_end;

  wire [44:0] dut_out = {init, cnt_up, round_idx, out_load, chain, pass_sel, nonce,
                         increment, busy, hash_done, found, exhausted};
  wire [42:0] s_out   = {s_init, s_cnt_up, s_round_idx, s_out_load, s_chain, s_pass_sel, s_nonce,
                         s_increment, s_busy, s_hash_done, s_found, s_exhausted};

  hm_multipass_ctrl #(.NUM_PASSES(NP), .PASS_W(2), .ROUNDS(R), .ROUND_W(2), .NONCE_W(32)) dut (
    .clk(clk), .n_rst(n_rst), .begin_hash(beg), .quit_hash(quit),
    .nonce_start(ns), .nonce_end(ne), .valid_hash_flag(flag),
    .init(init), .cnt_up(cnt_up), .round_idx(round_idx), .out_load(out_load),
    .chain(chain), .pass_sel(pass_sel), .nonce(nonce), .increment(increment),
    .busy(busy), .hash_done(hash_done), .found(found), .exhausted(exhausted)
  );

  hm_multipass_ctrl #(.NUM_PASSES(1), .PASS_W(1), .ROUNDS(2), .ROUND_W(1), .NONCE_W(32)) dut1 (
    .clk(clk), .n_rst(n_rst), .begin_hash(s_beg), .quit_hash(s_quit),
    .nonce_start(s_ns), .nonce_end(s_ne), .valid_hash_flag(s_flag),
    .init(s_init), .cnt_up(s_cnt_up), .round_idx(s_round_idx), .out_load(s_out_load),
    .chain(s_chain), .pass_sel(s_pass_sel), .nonce(s_nonce), .increment(s_increment),
    .busy(s_busy), .hash_done(s_hash_done), .found(s_found), .exhausted(s_exhausted)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_mode = 0; m_off = 0; m_nonce = '0; m_end = '0;
  endtask

  task automatic model_step();
    if (quit) begin
      m_mode = 0; m_off = 0;
    end else begin
      case (m_mode)
        0, 3: if (beg) begin m_nonce = ns; m_end = ne; m_mode = 1; m_off = 0; end
        1: begin
          if (m_off == A - 2) begin
            if (flag) m_mode = 2;
            else if (m_nonce == m_end) m_mode = 3;
            else m_off++;
          end else if (m_off == A - 1) begin
            m_nonce = m_nonce + 32'd1; m_off = 0;
          end else m_off++;
        end
        default: if (beg) begin
          if (m_nonce == m_end) m_mode = 3;
          else begin m_mode = 1; m_off = A - 1; end
        end
      endcase
    end
  endtask

  function automatic logic [44:0] model_out();
    logic i = 0, c = 0, ol = 0, inc = 0, b = 0, hd = 0, f = 0, ex = 0;
    int p = 0, rd = 0, q;
    case (m_mode)
      1: begin
        b = 1;
        if (m_off < NP * (R + 2)) begin
          p = m_off / (R + 2); q = m_off % (R + 2);
          i = (q == 0); c = (q >= 1 && q <= R); ol = (q == R + 1);
          if (c) rd = q - 1;
        end else begin
          p = NP - 1; hd = (m_off == A - 2); inc = (m_off == A - 1);
        end
      end
      2: begin p = NP - 1; hd = 1; f = 1; end
      3: begin p = NP - 1; hd = 1; ex = 1; end
      default: ;
    endcase
    return {i, c, 2'(rd), ol, (p > 0), 2'(p), m_nonce, inc, b, hd, f, ex};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    n_tests++; if (dut_out !== '0) begin n_fail++; $display("FAIL reset_por: got %h expected 0", dut_out); end
    n_tests++; if (s_out !== '0) begin n_fail++; $display("FAIL reset_por_1pass: got %h expected 0", s_out); end
    @(negedge clk); n_rst = 1'b1; model_reset();
    ns = 32'd5; ne = 32'd9; beg = 1'b1;
    tick(); beg = 1'b0;
    tick(); tick();
    n_tests++; if (cnt_up !== 1'b1 || dut_out !== model_out()) begin n_fail++; $display("FAIL reset_pre_calc: got %h expected %h", dut_out, model_out()); end
    #2 n_rst = 1'b0;
    #1;
    model_reset();
    n_tests++; if (dut_out !== '0) begin n_fail++; $display("FAIL reset_mid_calc: got %h expected 0", dut_out); end
    n_tests++; if (s_out !== '0) begin n_fail++; $display("FAIL reset_mid_calc_1pass: got %h expected 0", s_out); end
    @(negedge clk); n_rst = 1'b1;
  endtask

  task automatic test_nominal();
    ns = 32'd5; ne = 32'd9; flag = 1'b0; beg = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      tick(); beg = 1'b0;
      n_tests++; if (dut_out !== model_out()) begin n_fail++; $display("FAIL nominal_c%0d: got %h expected %h", c, dut_out, model_out()); end
      n_tests++; if (init !== (c == 1 || c == 7 || c == 13 || c == 21)) begin n_fail++; $display("FAIL nominal_init_c%0d: got %b", c, init); end
      n_tests++; if (hash_done !== (c == 19)) begin n_fail++; $display("FAIL nominal_done_c%0d: got %b", c, hash_done); end
      n_tests++; if (increment !== (c == 20)) begin n_fail++; $display("FAIL nominal_incr_c%0d: got %b", c, increment); end
    end
    n_tests++; if (nonce !== 32'd6) begin n_fail++; $display("FAIL nominal_nonce: got %h expected 6", nonce); end
  endtask

  task automatic test_found();
    flag = 1'b1;
    for (int k = 0; k < 100 && found !== 1'b1; k++) begin
      tick();
      n_tests++; if (dut_out !== model_out()) begin n_fail++; $display("FAIL found_trace: got %h expected %h", dut_out, model_out()); end
    end
    flag = 1'b0;
    n_tests++; if (found !== 1'b1 || nonce !== 32'd6 || busy !== 1'b0) begin n_fail++; $display("FAIL found_hold: found %b nonce %h busy %b, expected 1 6 0", found, nonce, busy); end
    beg = 1'b1; tick(); beg = 1'b0;
    n_tests++; if (increment !== 1'b1 || found !== 1'b0) begin n_fail++; $display("FAIL found_resume_incr: incr %b found %b expected 1 0", increment, found); end
    tick();
    n_tests++; if (nonce !== 32'd7 || init !== 1'b1 || dut_out !== model_out()) begin n_fail++; $display("FAIL found_resume_nonce: got %h expected %h", dut_out, model_out()); end
  endtask

  task automatic test_quit();
    flag = 1'b1;
    for (int k = 0; k < 100 && found !== 1'b1; k++) tick();
    flag = 1'b0;
    n_tests++; if (found !== 1'b1) begin n_fail++; $display("FAIL quit_reach_hold: found %b expected 1", found); end
    quit = 1'b1; beg = 1'b1; tick(); quit = 1'b0; beg = 1'b0;
    n_tests++; if (found !== 1'b0 || busy !== 1'b0 || hash_done !== 1'b0 || dut_out !== model_out()) begin n_fail++; $display("FAIL quit_hold: got %h expected %h", dut_out, model_out()); end
    ns = 32'd20; ne = 32'd30; beg = 1'b1; tick(); beg = 1'b0;
    for (int k = 0; k < 50 && !(out_load === 1'b1 && pass_sel === 2'd1); k++) tick();
    n_tests++; if (out_load !== 1'b1 || pass_sel !== 2'd1) begin n_fail++; $display("FAIL quit_reach_outload: out_load %b pass %0d expected 1 1", out_load, pass_sel); end
    quit = 1'b1; tick(); quit = 1'b0;
    n_tests++; if (busy !== 1'b0 || pass_sel !== 2'd0 || out_load !== 1'b0 || nonce !== 32'd20) begin n_fail++; $display("FAIL quit_outload: busy %b pass %0d nonce %h expected 0 0 20", busy, pass_sel, nonce); end
  endtask

  task automatic test_wrap();
    logic [31:0] tried[$];
    ns = 32'hFFFF_FFFE; ne = 32'hFFFF_FFFE; beg = 1'b1;
    for (int c = 1; c <= A; c++) begin
      tick(); beg = 1'b0;
      n_tests++; if (increment !== 1'b0 || dut_out !== model_out()) begin n_fail++; $display("FAIL wrap_single_c%0d: got %h expected %h", c, dut_out, model_out()); end
    end
    n_tests++; if (exhausted !== 1'b1 || nonce !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL wrap_exhaust: exhausted %b nonce %h expected 1 fffffffe", exhausted, nonce); end
    ns = 32'hFFFF_FFFF; ne = 32'h0000_0001; beg = 1'b1;
    for (int k = 0; k < 200 && (k == 0 || exhausted !== 1'b1); k++) begin
      tick(); beg = 1'b0;
      if (init === 1'b1 && pass_sel === 2'd0) tried.push_back(nonce);
      n_tests++; if (dut_out !== model_out()) begin n_fail++; $display("FAIL wrap_trace: got %h expected %h", dut_out, model_out()); end
    end
    n_tests++; if (exhausted !== 1'b1 || tried.size() != 3) begin n_fail++; $display("FAIL wrap_count: exhausted %b attempts %0d expected 1 3", exhausted, tried.size()); end
    else begin
      n_tests++; if (tried[0] !== 32'hFFFF_FFFF || tried[1] !== 32'h0 || tried[2] !== 32'h1) begin n_fail++; $display("FAIL wrap_nonces: got %h %h %h expected ffffffff 0 1", tried[0], tried[1], tried[2]); end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      beg  = ($urandom_range(0, 2) == 0);
      quit = ($urandom_range(0, 49) == 0);
      flag = ($urandom_range(0, 5) == 0);
      ns   = $urandom;
      ne   = ns + 32'($urandom_range(0, 2));
      tick();
      n_tests++; if (dut_out !== model_out()) begin n_fail++; $display("FAIL random_k%0d: got %h expected %h", k, dut_out, model_out()); end
    end
    beg = 1'b0; quit = 1'b1; flag = 1'b0; tick(); quit = 1'b0;
  endtask

  task automatic test_single_pass();
    int starts[$];
    s_ns = 32'd0; s_ne = 32'd3; s_flag = 1'b0; s_beg = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick(); s_beg = 1'b0;
      if (s_init === 1'b1) starts.push_back(c);
      n_tests++; if (s_chain !== 1'b0 || s_pass_sel !== 1'b0) begin n_fail++; $display("FAIL single_pass_c%0d: chain %b pass %b expected 0 0", c, s_chain, s_pass_sel); end
    end
    n_tests++; if (starts.size() != 4 || s_exhausted !== 1'b1) begin n_fail++; $display("FAIL single_pass_attempts: got %0d exhausted %b expected 4 1", starts.size(), s_exhausted); end
    for (int i = 1; i < starts.size(); i++) begin
      n_tests++; if (starts[i] - starts[i-1] != 6) begin n_fail++; $display("FAIL single_pass_len: got %0d expected 6", starts[i] - starts[i-1]); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_nominal();
    test_found();
    test_quit();
    test_wrap();
    test_random();
    test_single_pass();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
